sprite_blitter: RTL and testbench

Draws one 8x8 sprite onto the 160x120 VGA frame at a tile position of the 20x15 board grid. Sits between the game-state renderer (which issues one draw request per tile) and the VGA adapter. It walks the 64 pixels of the tile in raster order, drives row/column/sprite-id addresses into the sprite colour lookup, and registers the returned 12-bit RGB with the matching screen coordinate into a one-pixel-per-cycle plot stream.

---
 rtl/sokoban_pkg.sv | 18 +
 rtl/tile_pixel_counter.sv | 24 ++
 rtl/sprite_blitter.sv | 114 +++++++++++
 tb/tb_sprite_blitter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sokoban_pkg.sv
// Shared constants and types for the sokoban video path.
// Screen geometry, board tiling and blitter state encoding.
package sokoban_pkg;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int TILE_PX   = 8;
  localparam int TILE_COLS = SCREEN_W / TILE_PX;
  localparam int TILE_ROWS = SCREEN_H / TILE_PX;
  localparam int RGB_W     = 12;

  typedef enum logic [1:0] {
    BLIT_IDLE,
    BLIT_DRAW,
    BLIT_FLUSH
  } blit_state_t;

endpackage

// File: rtl/tile_pixel_counter.sv
// 6-bit raster counter over the 64 pixels of one tile.
// Low three bits are the column, high three the row.
module tile_pixel_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clr,
  input  logic       en,
  output logic [5:0] cnt,
  output logic       last
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= 6'd0;
    end else if (clr) begin
      cnt <= 6'd0;
    end else if (en) begin
      cnt <= cnt + 6'd1;
    end
  end

  assign last = (cnt == 6'd63);

endmodule

// File: rtl/sprite_blitter.sv
// Walks one 8x8 tile in raster order through the colour lookup
// and emits a registered one-pixel-per-cycle plot stream.
module sprite_blitter #(
  parameter int TILE_COLS = sokoban_pkg::TILE_COLS,
  parameter int TILE_ROWS = sokoban_pkg::TILE_ROWS
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic [4:0]                    tile_col,
  input  logic [3:0]                    tile_row,
  input  logic [2:0]                    sprite_sel,
  output logic [2:0]                    get_x,
  output logic [2:0]                    get_y,
  output logic [2:0]                    sprite_id,
  input  logic [sokoban_pkg::RGB_W-1:0] color_data,
  output logic [7:0]                    x_out,
  output logic [6:0]                    y_out,
  output logic [sokoban_pkg::RGB_W-1:0] color_out,
  output logic                          plot,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  import sokoban_pkg::*;

  blit_state_t state, state_n;

  logic [4:0] col_q;
  logic [3:0] row_q;
  logic [2:0] id_q;
  logic [5:0] cnt;
  logic       last;
  logic       in_range;
  logic       accept;
  logic       reject;

  assign in_range = (tile_col < 5'(TILE_COLS))
                 && (tile_row < 4'(TILE_ROWS));

  tile_pixel_counter u_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (accept),
    .en     (state == BLIT_DRAW),
    .cnt    (cnt),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= BLIT_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    unique case (state)
      BLIT_IDLE: begin
        if (start && in_range) begin
          accept  = 1'b1;
          state_n = BLIT_DRAW;
        end else if (start) begin
          reject  = 1'b1;
        end
      end
      BLIT_DRAW: begin
        if (last) state_n = BLIT_FLUSH;
      end
      BLIT_FLUSH: begin
        state_n = BLIT_IDLE;
      end
      default: begin
        state_n = BLIT_IDLE;
      end
    endcase
  end

  // One pipeline stage: the address shown this cycle plots next cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col_q     <= 5'd0;
      row_q     <= 4'd0;
      id_q      <= 3'd0;
      x_out     <= 8'd0;
      y_out     <= 7'd0;
      color_out <= '0;
      plot      <= 1'b0;
      err       <= 1'b0;
    end else begin
      plot <= (state == BLIT_DRAW);
      err  <= reject;
      if (accept) begin
        col_q <= tile_col;
        row_q <= tile_row;
        id_q  <= sprite_sel;
      end
      if (state == BLIT_DRAW) begin
        x_out     <= {col_q, 3'b000} + {5'b0, cnt[2:0]};
        y_out     <= {row_q, 3'b000} + {4'b0, cnt[5:3]};
        color_out <= color_data;
      end
    end
  end

  assign get_x     = cnt[2:0];
  assign get_y     = cnt[5:3];
  assign sprite_id = id_q;
  assign busy      = (state != BLIT_IDLE);
  assign done      = (state == BLIT_FLUSH);

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural colour lookup.
// Vector table of tile requests plus multi-cycle corner sequences.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  tile_col = 5'd0;
  logic [3:0]  tile_row = 4'd0;
  logic [2:0]  sprite_sel = 3'd0;
  logic [2:0]  get_x, get_y, sprite_id;
  logic [11:0] color_data;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [11:0] color_out;
  logic        plot, busy, done, err;

  sprite_blitter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .tile_col   (tile_col),
    .tile_row   (tile_row),
    .sprite_sel (sprite_sel),
    .get_x      (get_x),
    .get_y      (get_y),
    .sprite_id  (sprite_id),
    .color_data (color_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .color_out  (color_out),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  assign color_data = {sprite_id, get_y, get_x, get_x ^ get_y};

  typedef struct {
    int col;
    int row;
    int sel;
    bit ok;
  } vec_t;

  vec_t tbl[7];
  int nvec = 0;
  int nfail = 0;
  int last_x = 0;
  int last_y = 0;
  int last_c = 0;

  function automatic logic [11:0] mdl(input int sel, input int py,
                                      input int px);
    logic [2:0] s, y, x;
    s = 3'(sel);
    y = 3'(py);
    x = 3'(px);
    return {s, y, x, x ^ y};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first cycle after acceptance; leaves in the done cycle.
  task automatic check_draw(input int col, input int row,
                            input int sel, input bit poke);
    int px, py;
    chk("acc_busy", 32'(busy), 1);
    chk("acc_plot", 32'(plot), 0);
    chk("acc_get_x", 32'(get_x), 0);
    chk("acc_get_y", 32'(get_y), 0);
    chk("acc_sid", 32'(sprite_id), sel);
    for (int i = 0; i < 64; i++) begin
      step();
      if (poke && i == 10) begin
        tile_col = 5'd25;
        tile_row = 4'd2;
      end
      if (poke && i == 11) chk("busy_err", 32'(err), 0);
      if (poke && i == 20) begin
        tile_col   = 5'd10;
        tile_row   = 4'd3;
        sprite_sel = 3'd6;
      end
      px = i % 8;
      py = i / 8;
      chk("plot", 32'(plot), 1);
      chk("x_out", 32'(x_out), col * 8 + px);
      chk("y_out", 32'(y_out), row * 8 + py);
      chk("color", 32'(color_out), 32'(mdl(sel, py, px)));
      chk("done", 32'(done), (i == 63) ? 1 : 0);
      chk("busy", 32'(busy), 1);
    end
    last_x = col * 8 + 7;
    last_y = row * 8 + 7;
    last_c = int'(mdl(sel, 7, 7));
  endtask

  task automatic run_vec(input vec_t v);
    tile_col   = 5'(v.col);
    tile_row   = 4'(v.row);
    sprite_sel = 3'(v.sel);
    start      = 1'b1;
    step();
    start = 1'b0;
    if (v.ok) begin
      check_draw(v.col, v.row, v.sel, 1'b0);
      step();
      chk("end_busy", 32'(busy), 0);
      chk("end_plot", 32'(plot), 0);
      chk("end_done", 32'(done), 0);
      chk("hold_x", 32'(x_out), last_x);
      chk("hold_y", 32'(y_out), last_y);
      chk("hold_c", 32'(color_out), last_c);
    end else begin
      chk("rej_err", 32'(err), 1);
      chk("rej_busy", 32'(busy), 0);
      chk("rej_plot", 32'(plot), 0);
      chk("rej_hold_x", 32'(x_out), last_x);
      step();
      chk("rej_err_pulse", 32'(err), 0);
      chk("rej_busy2", 32'(busy), 0);
      chk("rej_plot2", 32'(plot), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x"}, 32'(x_out), 0);
    chk({tag, "_y"}, 32'(y_out), 0);
    chk({tag, "_c"}, 32'(color_out), 0);
    chk({tag, "_plot"}, 32'(plot), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_gx"}, 32'(get_x), 0);
    chk({tag, "_gy"}, 32'(get_y), 0);
    chk({tag, "_sid"}, 32'(sprite_id), 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 2, 1'b1};
    tbl[1] = '{19, 14, 5, 1'b1};
    tbl[2] = '{20, 0, 1, 1'b0};
    tbl[3] = '{0, 15, 3, 1'b0};
    tbl[4] = '{7, 9, 7, 1'b1};
    tbl[5] = '{31, 15, 0, 1'b0};
    tbl[6] = '{19, 0, 4, 1'b1};

    step();
    step();
    check_reset_outputs("rst");
    resetn = 1'b1;
    step();
    check_reset_outputs("post_rst");

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // start held high: back-to-back draws, busy-time changes ignored
    tile_col   = 5'd3;
    tile_row   = 4'd4;
    sprite_sel = 3'd1;
    start      = 1'b1;
    step();
    check_draw(3, 4, 1, 1'b1);
    step();
    chk("gap_busy", 32'(busy), 0);
    chk("gap_plot", 32'(plot), 0);
    chk("gap_err", 32'(err), 0);
    step();
    check_draw(10, 3, 6, 1'b0);
    start = 1'b0;
    step();
    chk("held_end_busy", 32'(busy), 0);
    step();
    chk("held_no_restart", 32'(busy), 0);
    chk("held_no_plot", 32'(plot), 0);

    // reset asserted while the 30th pixel is on the plot stream
    tile_col   = 5'd5;
    tile_row   = 4'd5;
    sprite_sel = 3'd4;
    start      = 1'b1;
    step();
    start = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    for (int i = 0; i < 30; i++) step();
    chk("mid_plot30", 32'(plot), 1);
    chk("mid_x30", 32'(x_out), 5 * 8 + 5);
    chk("mid_y30", 32'(y_out), 5 * 8 + 3);
    resetn = 1'b0;
    step();
    check_reset_outputs("mid_rst");
    resetn = 1'b1;
    last_x = 0;
    last_y = 0;
    last_c = 0;
    run_vec('{6, 7, 3, 1'b1});

    // reset and start in the same cycle: reset wins
    resetn   = 1'b0;
    start    = 1'b1;
    tile_col = 5'd1;
    tile_row = 4'd1;
    step();
    check_reset_outputs("rst_start");
    resetn = 1'b1;
    start  = 1'b0;
    step();
    chk("rst_start_busy", 32'(busy), 0);
    chk("rst_start_plot", 32'(plot), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
